romulus_lfsr_ctr: RTL

Parametrised Galois-LFSR block counter for the Romulus tweakey path. It generalises the fixed 56-bit domain counter to a configurable width, feedback polynomial and seed. It adds a multi-step request handshake, a linear step count, and a usage-limit guard. It sits beside the tweakey schedule in the mode controller, which requests 1 step per message block or 2 steps per AD double-block and samples `state_o` when `done_o` is high.

---
 rtl/romulus_lfsr_ctr.sv | 117 +++++++++++
 1 files changed

// File: rtl/romulus_lfsr_ctr.sv
// Galois-LFSR block counter for the Romulus tweakey path, with multi-step requests and a usage-limit guard.
// Latency: n+1 cycles from request acceptance to done_o; zero-step and rejected requests answer in 1 cycle.
// Backpressure: ready_o low while stepping; step_i is ignored (not queued) while busy or while init_i is high.
module romulus_lfsr_ctr #(
    parameter int unsigned    W     = 56,
    parameter logic [W-1:0]   POLY  = 'h95,
    parameter logic [W-1:0]   INIT  = 'h1,
    parameter int unsigned    SW    = 4,
    parameter int unsigned    CW    = 16,
    parameter int unsigned    LIMIT = (2 ** CW) - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_i,
    input  logic          step_i,
    input  logic [SW-1:0] nstep_i,
    output logic          ready_o,
    output logic          done_o,
    output logic          err_o,
    output logic [W-1:0]  state_o,
    output logic [CW-1:0] cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    localparam logic [CW:0] LIMIT_C = (CW+1)'(LIMIT);

    fsm_t          fsm_q, fsm_d;
    logic [SW-1:0] rem_q, rem_d;
    logic [W-1:0]  lfsr_q, lfsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [W-1:0]  lfsr_next;
    logic [CW:0]   cnt_sum;
    logic          over_limit;

    // One Galois advance: shift left, fold the feedback mask in when the MSB falls out.
    assign lfsr_next  = {lfsr_q[W-2:0], 1'b0} ^ (lfsr_q[W-1] ? POLY : '0);

    // Guard sum carries one extra bit so the count can never wrap past LIMIT.
    assign cnt_sum    = {1'b0, cnt_q} + (CW+1)'(nstep_i);
    assign over_limit = (cnt_sum > LIMIT_C);

    // State registers; reset puts the seed back and returns to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            rem_q  <= '0;
            lfsr_q <= INIT;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            rem_q  <= rem_d;
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Next-state: init dominates, idle decides accept/reject/trivial, run applies one advance per cycle.
    always_comb begin
        fsm_d  = fsm_q;
        rem_d  = rem_q;
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        if (init_i) begin
            fsm_d  = IDLE;
            rem_d  = '0;
            lfsr_d = INIT;
            cnt_d  = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (step_i) begin
                        if (over_limit) begin
                            err_d = 1'b1;
                        end else if (nstep_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            rem_d = nstep_i;
                            fsm_d = RUN;
                        end
                    end
                end
                RUN: begin
                    lfsr_d = lfsr_next;
                    cnt_d  = cnt_q + CW'(1);
                    rem_d  = rem_q - SW'(1);
                    if (rem_q == SW'(1)) begin
                        fsm_d  = IDLE;
                        done_d = 1'b1;
                    end
                end
                default: begin
                    fsm_d = IDLE;
                end
            endcase
        end
    end

    assign ready_o = (fsm_q == IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign state_o = lfsr_q;
    assign cnt_o   = cnt_q;

endmodule
